// File: rtl/dm_store_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : dm_store_buffer
//  Description : FIFO store buffer between the MEM-stage store path and the
//                data-memory write port. It queues word-addressed stores and
//                drains one per cycle while drain_en is high. It also flags
//                loads whose address matches any pending store.
//  Ports       : clk, reset (sync, active-high)
//                st_valid/st_addr/st_data/st_be -> st_ready   store enqueue
//                ld_valid/ld_addr -> ld_hazard               load hazard check
//                drain_en -> dm_we/dm_addr/dm_wdata/dm_be     DM write port
//                count, empty                                 occupancy
//  Revision    : 1.0  initial release
// ============================================================================
module dm_store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 12,
    parameter int DW    = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       st_valid,
    input  logic [AW-1:0]              st_addr,
    input  logic [DW-1:0]              st_data,
    input  logic [3:0]                 st_be,
    output logic                       st_ready,
    input  logic                       ld_valid,
    input  logic [AW-1:0]              ld_addr,
    output logic                       ld_hazard,
    input  logic                       drain_en,
    output logic                       dm_we,
    output logic [AW-1:0]              dm_addr,
    output logic [DW-1:0]              dm_wdata,
    output logic [3:0]                 dm_be,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty
);

    localparam int              c_PW    = $clog2(DEPTH);
    localparam logic [c_PW:0]   c_DEPTH = (c_PW+1)'(DEPTH);
    localparam logic [c_PW-1:0] c_PONE  = c_PW'(1);
    localparam logic [c_PW:0]   c_CONE  = (c_PW+1)'(1);

    logic [AW-1:0]    r_addr  [DEPTH];
    logic [DW-1:0]    r_data  [DEPTH];
    logic [3:0]       r_be    [DEPTH];
    logic [DEPTH-1:0] r_valid;
    logic [c_PW-1:0]  r_wr_ptr;
    logic [c_PW-1:0]  r_rd_ptr;
    logic [c_PW:0]    r_count;

    logic w_empty;
    logic w_enq;
    logic w_deq;
    logic w_hit;

    assign w_empty  = (r_count == '0);
    // Ready depends on occupancy only, so a same-cycle drain never opens a
    // slot for a store arriving while full.
    assign st_ready = (r_count != c_DEPTH);
    // A zero byte-enable request carries no data and is dropped.
    assign w_enq    = st_valid & st_ready & (st_be != 4'b0000);
    // The write strobe is suppressed during reset so pending stores being
    // discarded are never committed to DM at the reset edge.
    assign w_deq    = drain_en & ~w_empty & ~reset;

    assign dm_we    = w_deq;
    assign dm_addr  = w_empty ? '0 : r_addr[r_rd_ptr];
    assign dm_wdata = w_empty ? '0 : r_data[r_rd_ptr];
    assign dm_be    = w_empty ? '0 : r_be[r_rd_ptr];
    assign count    = r_count;
    assign empty    = w_empty;

    // Only registered entries are compared; the head being drained this
    // cycle is still valid and therefore still blocks the load.
    always_comb begin
        w_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_valid[i] && (r_addr[i] == ld_addr)) begin
                w_hit = 1'b1;
            end
        end
    end

    assign ld_hazard = ld_valid & w_hit;

    // Payload storage needs no reset: it is only observed through valid bits
    // and the empty mask.
    always_ff @(posedge clk) begin
        if (w_enq && !reset) begin
            r_addr[r_wr_ptr] <= st_addr;
            r_data[r_wr_ptr] <= st_data;
            r_be[r_wr_ptr]   <= st_be;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_valid  <= '0;
        end else begin
            if (w_enq) begin
                r_wr_ptr           <= r_wr_ptr + c_PONE;
                r_valid[r_wr_ptr]  <= 1'b1;
            end
            if (w_deq) begin
                r_rd_ptr           <= r_rd_ptr + c_PONE;
                r_valid[r_rd_ptr]  <= 1'b0;
            end
            // When full, enqueue is blocked, so wr_ptr == rd_ptr cannot be a
            // simultaneous set/clear of the same valid bit.
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + c_CONE;
                2'b01:   r_count <= r_count - c_CONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dm_store_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dm_store_buffer
//  Description : Directed self-checking bench for dm_store_buffer.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dm_store_buffer;

    localparam int DEPTH = 4;
    localparam int AW    = 12;
    localparam int DW    = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          st_valid;
    logic [AW-1:0] st_addr;
    logic [DW-1:0] st_data;
    logic [3:0]    st_be;
    logic          st_ready;
    logic          ld_valid;
    logic [AW-1:0] ld_addr;
    logic          ld_hazard;
    logic          drain_en;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic [3:0]    dm_be;
    logic [2:0]    count;
    logic          empty;

    int checks = 0;
    int errors = 0;

    dm_store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .st_valid  (st_valid),
        .st_addr   (st_addr),
        .st_data   (st_data),
        .st_be     (st_be),
        .st_ready  (st_ready),
        .ld_valid  (ld_valid),
        .ld_addr   (ld_addr),
        .ld_hazard (ld_hazard),
        .drain_en  (drain_en),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_be     (dm_be),
        .count     (count),
        .empty     (empty)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 2 units
    // after the rising edge, well away from it.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        st_valid = 1'b0; st_addr = '0; st_data = '0; st_be = 4'h0;
        ld_valid = 1'b0; ld_addr = '0; drain_en = 1'b0;
    endtask

    task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] be);
        st_valid = 1'b1; st_addr = a; st_data = d; st_be = be;
        tick();
        st_valid = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        drain_en = 1'b1; ld_valid = 1'b1; ld_addr = '0;
        settle();
        checks++;
        if (st_ready !== 1'b1 || ld_hazard !== 1'b0 || dm_we !== 1'b0 ||
            dm_addr !== '0 || dm_wdata !== '0 || dm_be !== 4'h0 ||
            count !== 3'd0 || empty !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: rdy=%b haz=%b we=%b addr=%h wd=%h be=%h cnt=%0d empty=%b, required 1 0 0 0 0 0 0 1",
                     st_ready, ld_hazard, dm_we, dm_addr, dm_wdata, dm_be, count, empty);
        end
        idle_inputs();
    endtask

    task automatic test_fill();
        drain_en = 1'b0;
        for (int i = 0; i < 4; i++) push(12'h010 + 12'(i), 32'hC0DE_0000 + 32'(i), 4'hF);
        settle();
        checks++;
        if (count !== 3'd4 || st_ready !== 1'b0 || dm_we !== 1'b0 || dm_addr !== 12'h010) begin
            errors++;
            $display("FAIL fill: cnt=%0d rdy=%b we=%b head=%h, required 4 0 0 010", count, st_ready, dm_we, dm_addr);
        end
        push(12'h099, 32'hDEAD_BEEF, 4'hF);
        settle();
        checks++;
        if (count !== 3'd4) begin
            errors++;
            $display("FAIL fifth_store_ignored: cnt=%0d, required 4", count);
        end
    endtask

    task automatic test_drain();
        drain_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            settle();
            checks++;
            if (dm_we !== 1'b1 || dm_addr !== 12'h010 + 12'(i) ||
                dm_wdata !== 32'hC0DE_0000 + 32'(i) || dm_be !== 4'hF) begin
                errors++;
                $display("FAIL drain_%0d: we=%b addr=%h data=%h be=%h, required 1 %h %h f",
                         i, dm_we, dm_addr, dm_wdata, dm_be, 12'h010 + 12'(i), 32'hC0DE_0000 + 32'(i));
            end
            tick();
        end
        settle();
        checks++;
        if (dm_we !== 1'b0 || empty !== 1'b1 || dm_addr !== '0 || dm_wdata !== '0) begin
            errors++;
            $display("FAIL drain_done: we=%b empty=%b addr=%h data=%h, required 0 1 0 0", dm_we, empty, dm_addr, dm_wdata);
        end
        drain_en = 1'b0;
    endtask

    task automatic test_steady();
        drain_en = 1'b1;
        for (int k = 0; k < 12; k++) begin
            st_valid = 1'b1; st_addr = 12'h100 + 12'(k); st_data = 32'hA000 + 32'(k); st_be = 4'hF;
            settle();
            checks++;
            if (k == 0) begin
                if (count !== 3'd0 || dm_we !== 1'b0) begin
                    errors++;
                    $display("FAIL steady_first: cnt=%0d we=%b, required 0 0", count, dm_we);
                end
            end else if (count !== 3'd1 || dm_we !== 1'b1 ||
                         dm_addr !== 12'h100 + 12'(k - 1) || dm_wdata !== 32'hA000 + 32'(k - 1)) begin
                errors++;
                $display("FAIL steady_%0d: cnt=%0d we=%b addr=%h data=%h, required 1 1 %h %h",
                         k, count, dm_we, dm_addr, dm_wdata, 12'h100 + 12'(k - 1), 32'hA000 + 32'(k - 1));
            end
            tick();
        end
        st_valid = 1'b0;
        settle();
        checks++;
        if (dm_we !== 1'b1 || dm_addr !== 12'h10B || dm_wdata !== 32'hA00B) begin
            errors++;
            $display("FAIL steady_last: we=%b addr=%h data=%h, required 1 10b a00b", dm_we, dm_addr, dm_wdata);
        end
        tick();
        settle();
        checks++;
        if (empty !== 1'b1 || dm_we !== 1'b0) begin
            errors++;
            $display("FAIL steady_empty: empty=%b we=%b, required 1 0", empty, dm_we);
        end
        drain_en = 1'b0;
    endtask

    task automatic test_be_zero();
        push(12'h055, 32'h1234_5678, 4'h0);
        settle();
        checks++;
        if (count !== 3'd0 || empty !== 1'b1) begin
            errors++;
            $display("FAIL be_zero_noop: cnt=%0d empty=%b, required 0 1", count, empty);
        end
    endtask

    task automatic test_hazard();
        drain_en = 1'b0;
        push(12'h020, 32'h0000_00AB, 4'b0001);
        ld_valid = 1'b1; ld_addr = 12'h020;
        settle();
        checks++;
        if (ld_hazard !== 1'b1) begin
            errors++;
            $display("FAIL hazard_hit: haz=%b, required 1", ld_hazard);
        end
        ld_addr = 12'h021;
        settle();
        checks++;
        if (ld_hazard !== 1'b0) begin
            errors++;
            $display("FAIL hazard_miss: haz=%b, required 0", ld_hazard);
        end
        // A store presented this cycle is not yet an entry.
        st_valid = 1'b1; st_addr = 12'h021; st_data = 32'h1; st_be = 4'hF;
        settle();
        checks++;
        if (ld_hazard !== 1'b0) begin
            errors++;
            $display("FAIL hazard_same_cycle_store: haz=%b, required 0", ld_hazard);
        end
        st_valid = 1'b0;
        ld_valid = 1'b0; ld_addr = 12'h020;
        settle();
        checks++;
        if (ld_hazard !== 1'b0) begin
            errors++;
            $display("FAIL hazard_no_load: haz=%b, required 0", ld_hazard);
        end
        ld_valid = 1'b1; drain_en = 1'b1;
        settle();
        checks++;
        if (ld_hazard !== 1'b1 || dm_we !== 1'b1 || dm_be !== 4'b0001) begin
            errors++;
            $display("FAIL hazard_during_drain: haz=%b we=%b be=%b, required 1 1 0001", ld_hazard, dm_we, dm_be);
        end
        tick();
        drain_en = 1'b0;
        settle();
        checks++;
        if (ld_hazard !== 1'b0 || empty !== 1'b1) begin
            errors++;
            $display("FAIL hazard_cleared: haz=%b empty=%b, required 0 1", ld_hazard, empty);
        end
        ld_valid = 1'b0;
    endtask

    task automatic test_full_deq();
        drain_en = 1'b0;
        for (int i = 0; i < 4; i++) push(12'h030 + 12'(i), 32'hB000 + 32'(i), 4'hF);
        drain_en = 1'b1;
        st_valid = 1'b1; st_addr = 12'h034; st_data = 32'hB004; st_be = 4'hF;
        settle();
        checks++;
        if (st_ready !== 1'b0 || dm_we !== 1'b1 || dm_addr !== 12'h030) begin
            errors++;
            $display("FAIL full_deq_ready: rdy=%b we=%b addr=%h, required 0 1 030", st_ready, dm_we, dm_addr);
        end
        tick();
        settle();
        checks++;
        if (count !== 3'd3 || st_ready !== 1'b1) begin
            errors++;
            $display("FAIL full_deq_count: cnt=%0d rdy=%b, required 3 1", count, st_ready);
        end
        drain_en = 1'b0;
        tick();
        st_valid = 1'b0;
        settle();
        checks++;
        if (count !== 3'd4) begin
            errors++;
            $display("FAIL full_deq_accept: cnt=%0d, required 4", count);
        end
        drain_en = 1'b1;
        for (int i = 1; i < 5; i++) begin
            settle();
            checks++;
            if (dm_we !== 1'b1 || dm_addr !== 12'h030 + 12'(i) || dm_wdata !== 32'hB000 + 32'(i)) begin
                errors++;
                $display("FAIL full_deq_order_%0d: we=%b addr=%h data=%h, required 1 %h %h",
                         i, dm_we, dm_addr, dm_wdata, 12'h030 + 12'(i), 32'hB000 + 32'(i));
            end
            tick();
        end
        drain_en = 1'b0;
    endtask

    task automatic test_reset_mid();
        drain_en = 1'b0;
        for (int i = 0; i < 3; i++) push(12'h040 + 12'(i), 32'hE000 + 32'(i), 4'hF);
        reset = 1'b1; drain_en = 1'b1;
        settle();
        checks++;
        if (dm_we !== 1'b0 || count !== 3'd3) begin
            errors++;
            $display("FAIL reset_mid_we: we=%b cnt=%0d, required 0 3", dm_we, count);
        end
        tick();
        reset = 1'b0;
        settle();
        checks++;
        if (count !== 3'd0 || empty !== 1'b1 || st_ready !== 1'b1 || dm_we !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_after: cnt=%0d empty=%b rdy=%b we=%b, required 0 1 1 0",
                     count, empty, st_ready, dm_we);
        end
        drain_en = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_fill();
        test_drain();
        test_steady();
        test_be_zero();
        test_hazard();
        test_full_deq();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
